// File: rtl/p_hit_scheduler.sv
// p_hit_scheduler
//   Sequences one ray at a time through the external p_hit_1 ray/plane-hit
//   datapath. For each accepted ray it walks triangles 0..n-1 (n = tri_count
//   clamped to NUM_TRI). For each triangle it reads the triangle constants,
//   loads them as p_hit_1 operands, pushes one operand pair, pops the returned
//   distance t and keeps the closest positive hit. The final result sits in a
//   single-entry result register until the downstream stage consumes it.
//
// Ports
//   clock, reset                  rising-edge clock, async active-low reset
//   ray_origin/ray_dir[2:0]       ray operands, latched on accept
//   ray_valid / ray_ready         ray handshake (ready only in IDLE with no result pending)
//   tri_count                     triangles to test, sampled on accept
//   tri_addr / tri_rd_en          triangle table read (data valid one cycle after strobe)
//   tri_n1_in/tri_n2_in/tri_v0_in triangle table read data
//   dp_*                          p_hit_1 operands, input FIFO write and full flags
//   dp_out/dp_out_empty/rd_en     p_hit_1 output FIFO head, empty flag and pop
//   res_t/res_idx/res_hit         closest positive t, its triangle index, hit flag
//   res_empty / res_rd_en         result register status and consume strobe
//   busy                          high in every state except IDLE
module p_hit_scheduler #(
    parameter int Q_BITS  = 16,
    parameter int NUM_TRI = 16,
    parameter int TRI_AW  = $clog2(NUM_TRI)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       ray_origin      [2:0],
    input  logic [31:0]       ray_dir         [2:0],
    input  logic              ray_valid,
    output logic              ray_ready,
    input  logic [TRI_AW:0]   tri_count,
    output logic [TRI_AW-1:0] tri_addr,
    output logic              tri_rd_en,
    input  logic [31:0]       tri_n1_in       [2:0],
    input  logic [31:0]       tri_n2_in       [2:0],
    input  logic [31:0]       tri_v0_in       [2:0],
    output logic [31:0]       dp_tri_normal_1 [2:0],
    output logic [31:0]       dp_tri_normal_2 [2:0],
    output logic [31:0]       dp_v0           [2:0],
    output logic [31:0]       dp_origin       [2:0],
    output logic [31:0]       dp_dir          [2:0],
    output logic [1:0]        dp_in_wr_en,
    input  logic [1:0]        dp_in_full,
    input  logic [31:0]       dp_out,
    input  logic              dp_out_empty,
    output logic              dp_out_rd_en,
    output logic [31:0]       res_t,
    output logic [TRI_AW-1:0] res_idx,
    output logic              res_hit,
    output logic              res_empty,
    input  logic              res_rd_en,
    output logic              busy
);

    // Q_BITS only documents the fixed-point format of t/origin/dir; the
    // closest-hit compare is a plain signed compare and is scale-invariant.
    if (Q_BITS < 0 || Q_BITS > 31) begin : g_q_bits_unsupported
    end

    localparam logic [31:0]     MISS_T = 32'h7FFF_FFFF;
    localparam logic [TRI_AW:0] N_MAX  = (TRI_AW + 1)'(NUM_TRI);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        ISSUE,
        WAIT,
        CMP,
        DONE
    } state_e;

    state_e            state_q;
    logic [TRI_AW:0]   n_q;
    logic [TRI_AW:0]   n_d;
    logic [TRI_AW-1:0] idx_q;
    logic [31:0]       t_q;
    logic [31:0]       best_t_q;
    logic [TRI_AW-1:0] best_idx_q;
    logic              best_hit_q;
    logic              last_tri;
    logic              closer;

    logic [31:0]       dp_n1_q     [2:0];
    logic [31:0]       dp_n2_q     [2:0];
    logic [31:0]       dp_v0_q     [2:0];
    logic [31:0]       dp_origin_q [2:0];
    logic [31:0]       dp_dir_q    [2:0];
    logic [1:0]        dp_in_wr_en_q;
    logic              dp_out_rd_en_q;
    logic              tri_rd_en_q;
    logic [TRI_AW-1:0] tri_addr_q;
    logic [31:0]       res_t_q;
    logic [TRI_AW-1:0] res_idx_q;
    logic              res_hit_q;
    logic              res_empty_q;

    always_comb begin
        n_d      = (tri_count > N_MAX) ? N_MAX : tri_count;
        last_tri = ({1'b0, idx_q} == (n_q - 1'b1));
        closer   = ($signed(t_q) > 0) && ($signed(t_q) < $signed(best_t_q));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            n_q            <= '0;
            idx_q          <= '0;
            t_q            <= '0;
            best_t_q       <= MISS_T;
            best_idx_q     <= '1;
            best_hit_q     <= 1'b0;
            for (int unsigned i = 0; i < 3; i++) begin
                dp_n1_q[i]     <= '0;
                dp_n2_q[i]     <= '0;
                dp_v0_q[i]     <= '0;
                dp_origin_q[i] <= '0;
                dp_dir_q[i]    <= '0;
            end
            dp_in_wr_en_q  <= '0;
            dp_out_rd_en_q <= 1'b0;
            tri_rd_en_q    <= 1'b0;
            tri_addr_q     <= '0;
            res_t_q        <= MISS_T;
            res_idx_q      <= '1;
            res_hit_q      <= 1'b0;
            res_empty_q    <= 1'b1;
        end else begin
            // Strobes are single-cycle pulses unless a state re-asserts them.
            dp_in_wr_en_q  <= '0;
            dp_out_rd_en_q <= 1'b0;
            tri_rd_en_q    <= 1'b0;

            // A pending result can only exist while in IDLE, so the consume
            // never races the DONE write below.
            if (res_rd_en && !res_empty_q) begin
                res_empty_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (ray_valid && res_empty_q) begin
                        for (int unsigned i = 0; i < 3; i++) begin
                            dp_origin_q[i] <= ray_origin[i];
                            dp_dir_q[i]    <= ray_dir[i];
                        end
                        n_q        <= n_d;
                        idx_q      <= '0;
                        best_t_q   <= MISS_T;
                        best_idx_q <= '1;
                        best_hit_q <= 1'b0;
                        if (n_d == '0) begin
                            state_q <= DONE;
                        end else begin
                            // Read strobe is raised on entry so it is high
                            // during FETCH; data then arrives during LOAD.
                            tri_rd_en_q <= 1'b1;
                            tri_addr_q  <= '0;
                            state_q     <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    state_q <= LOAD;
                end
                LOAD: begin
                    for (int unsigned i = 0; i < 3; i++) begin
                        dp_n1_q[i] <= tri_n1_in[i];
                        dp_n2_q[i] <= tri_n2_in[i];
                        dp_v0_q[i] <= tri_v0_in[i];
                    end
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    if (dp_in_full == 2'b00) begin
                        dp_in_wr_en_q <= 2'b11;
                        state_q       <= WAIT;
                    end
                end
                WAIT: begin
                    if (!dp_out_empty) begin
                        t_q            <= dp_out;
                        dp_out_rd_en_q <= 1'b1;
                        state_q        <= CMP;
                    end
                end
                CMP: begin
                    // Strict less-than keeps the lower index on equal t.
                    if (closer) begin
                        best_t_q   <= t_q;
                        best_idx_q <= idx_q;
                        best_hit_q <= 1'b1;
                    end
                    if (last_tri) begin
                        state_q <= DONE;
                    end else begin
                        idx_q       <= idx_q + 1'b1;
                        tri_rd_en_q <= 1'b1;
                        tri_addr_q  <= idx_q + 1'b1;
                        state_q     <= FETCH;
                    end
                end
                DONE: begin
                    res_t_q     <= best_t_q;
                    res_idx_q   <= best_idx_q;
                    res_hit_q   <= best_hit_q;
                    res_empty_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Decoded purely from registers, so no input-to-output paths.
    assign ray_ready = (state_q == IDLE) && res_empty_q;
    assign busy      = (state_q != IDLE);

    assign dp_tri_normal_1 = dp_n1_q;
    assign dp_tri_normal_2 = dp_n2_q;
    assign dp_v0           = dp_v0_q;
    assign dp_origin       = dp_origin_q;
    assign dp_dir          = dp_dir_q;
    assign dp_in_wr_en     = dp_in_wr_en_q;
    assign dp_out_rd_en    = dp_out_rd_en_q;
    assign tri_rd_en       = tri_rd_en_q;
    assign tri_addr        = tri_addr_q;
    assign res_t           = res_t_q;
    assign res_idx         = res_idx_q;
    assign res_hit         = res_hit_q;
    assign res_empty       = res_empty_q;

endmodule
